// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - swap codes and lane-select decode shared by issue and writeback
// Purpose: names the six lane-swap codes an issued bundle can carry and decodes a
//          4-bit swap code into the per-slot source-lane selects.
// Contents: SWAP_* codes, lane_sel_t, lane_sel_vec_t, decode_swap().
package isa_pkg;

  // Bit 3 is instruction 1, bit 0 is instruction 4.
  localparam logic [3:0] SWAP_14 = 4'b1001;
  localparam logic [3:0] SWAP_24 = 4'b0101;
  localparam logic [3:0] SWAP_34 = 4'b0011;
  localparam logic [3:0] SWAP_12 = 4'b1100;
  localparam logic [3:0] SWAP_13 = 4'b1010;
  localparam logic [3:0] SWAP_23 = 4'b0110;

  // Lane number 0..3 standing for lanes 1..4.
  typedef logic [1:0] lane_sel_t;
  // Element [k-1] is the lane that program-order slot k reads from.
  typedef lane_sel_t [3:0] lane_sel_vec_t;

  // Every swap is a transposition, so the issue-side map is also its own inverse.
  function automatic lane_sel_vec_t decode_swap(input logic [3:0] code);
    lane_sel_vec_t sel;
    sel = {2'd3, 2'd2, 2'd1, 2'd0};
    case (code)
      SWAP_14: begin sel[0] = 2'd3; sel[3] = 2'd0; end
      SWAP_24: begin sel[1] = 2'd3; sel[3] = 2'd1; end
      SWAP_34: begin sel[2] = 2'd3; sel[3] = 2'd2; end
      SWAP_12: begin sel[0] = 2'd1; sel[1] = 2'd0; end
      SWAP_13: begin sel[0] = 2'd2; sel[2] = 2'd0; end
      SWAP_23: begin sel[1] = 2'd2; sel[2] = 2'd1; end
      default: ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/swap_tag_fifo.sv
// rtl/swap_tag_fifo.sv - in-order queue of decoded lane selects for in-flight bundles
// Purpose: DEPTH-entry synchronous FIFO with occupancy count and flush.
// Ports: clk, rst_n (async active-low), flush (sync clear, wins over push/pop),
//        push/din (write, ignored when full), pop (read, ignored when empty),
//        dout (head entry), full, empty.
module swap_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PTR_W wide, so wrap modulo DEPTH comes for free.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/result_unswap.sv
// rtl/result_unswap.sv - restores program order of the four lane results at writeback
// Purpose: records each bundle's swap code at issue and, when its results return,
//          routes lane sel[k] to output slot k through a registered 4-way mux.
// Ports: issue_vld/issue_swap/issue_rdy (tag push), wb_vld/wb_rdy + in_k_* (lane
//        results), out_vld/out_rdy + out_k_* (program-order bundle), flush,
//        err_underflw (sticky, results arrived with no recorded tag).
module result_unswap
  import isa_pkg::*;
#(
  parameter int des    = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_vld,
  input  logic [3:0]        issue_swap,
  output logic              issue_rdy,
  input  logic              wb_vld,
  output logic              wb_rdy,
  input  logic              in_1_vld,
  input  logic [des-1:0]    in_1_des,
  input  logic [DATA_W-1:0] in_1_data,
  input  logic              in_2_vld,
  input  logic [des-1:0]    in_2_des,
  input  logic [DATA_W-1:0] in_2_data,
  input  logic              in_3_vld,
  input  logic [des-1:0]    in_3_des,
  input  logic [DATA_W-1:0] in_3_data,
  input  logic              in_4_vld,
  input  logic [des-1:0]    in_4_des,
  input  logic [DATA_W-1:0] in_4_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_1_vld,
  output logic [des-1:0]    out_1_des,
  output logic [DATA_W-1:0] out_1_data,
  output logic              out_2_vld,
  output logic [des-1:0]    out_2_des,
  output logic [DATA_W-1:0] out_2_data,
  output logic              out_3_vld,
  output logic [des-1:0]    out_3_des,
  output logic [DATA_W-1:0] out_3_data,
  output logic              out_4_vld,
  output logic [des-1:0]    out_4_des,
  output logic [DATA_W-1:0] out_4_data,
  output logic              err_underflw
);

  logic [3:0]                 lane_vld;
  logic [3:0][des-1:0]        lane_des;
  logic [3:0][DATA_W-1:0]     lane_data;
  logic [3:0]                 slot_vld_q, slot_vld_d;
  logic [3:0][des-1:0]        slot_des_q, slot_des_d;
  logic [3:0][DATA_W-1:0]     slot_data_q, slot_data_d;
  logic                       out_vld_q, out_vld_d;
  logic                       err_q, err_d;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop;
  logic [7:0]                 head_raw;
  lane_sel_vec_t              head_sel;

  assign lane_vld  = {in_4_vld,  in_3_vld,  in_2_vld,  in_1_vld};
  assign lane_des  = {in_4_des,  in_3_des,  in_2_des,  in_1_des};
  assign lane_data = {in_4_data, in_3_data, in_2_data, in_1_data};

  assign issue_rdy = !fifo_full;
  assign wb_rdy    = !fifo_empty && (!out_vld_q || out_rdy);
  assign push      = issue_vld && issue_rdy;
  assign pop       = wb_vld && wb_rdy;
  assign head_sel  = lane_sel_vec_t'(head_raw);

  swap_tag_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(8)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (8'(decode_swap(issue_swap))),
    .pop   (pop),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_des_d  = slot_des_q;
    slot_data_d = slot_data_q;
    out_vld_d   = out_vld_q;
    err_d       = err_q;
    if (flush) begin
      out_vld_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      if (wb_vld && fifo_empty) err_d = 1'b1;
      if (pop) begin
        for (int k = 0; k < 4; k++) begin
          slot_vld_d[k]  = lane_vld[head_sel[k]];
          slot_des_d[k]  = lane_des[head_sel[k]];
          slot_data_d[k] = lane_data[head_sel[k]];
        end
        out_vld_d = 1'b1;
      end else if (out_rdy) begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q  <= '0;
      slot_des_q  <= '0;
      slot_data_q <= '0;
      out_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_des_q  <= slot_des_d;
      slot_data_q <= slot_data_d;
      out_vld_q   <= out_vld_d;
      err_q       <= err_d;
    end
  end

  // Slot data stays put after a drain; only the valids follow out_vld.
  assign out_vld      = out_vld_q;
  assign err_underflw = err_q;
  assign out_1_vld    = out_vld_q && slot_vld_q[0];
  assign out_2_vld    = out_vld_q && slot_vld_q[1];
  assign out_3_vld    = out_vld_q && slot_vld_q[2];
  assign out_4_vld    = out_vld_q && slot_vld_q[3];
  assign out_1_des    = slot_des_q[0];
  assign out_2_des    = slot_des_q[1];
  assign out_3_des    = slot_des_q[2];
  assign out_4_des    = slot_des_q[3];
  assign out_1_data   = slot_data_q[0];
  assign out_2_data   = slot_data_q[1];
  assign out_3_data   = slot_data_q[2];
  assign out_4_data   = slot_data_q[3];

endmodule

// File: tb/tb_result_unswap.sv
// tb/tb_result_unswap.sv - directed bench for result_unswap with a queue-based reference model
module tb_result_unswap;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic issue_vld = 1'b0;
  logic [3:0] issue_swap = 4'b0;
  logic issue_rdy;
  logic wb_vld = 1'b0;
  logic wb_rdy;
  logic [3:0] in_vld = 4'b0;
  logic [3:0][3:0] in_des = '0;
  logic [3:0][15:0] in_data = '0;
  logic out_vld;
  logic out_rdy = 1'b0;
  logic [3:0] o_vld;
  logic [3:0][3:0] o_des;
  logic [3:0][15:0] o_data;
  logic err_underflw;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  result_unswap dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_vld(issue_vld), .issue_swap(issue_swap), .issue_rdy(issue_rdy),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy),
    .in_1_vld(in_vld[0]), .in_1_des(in_des[0]), .in_1_data(in_data[0]),
    .in_2_vld(in_vld[1]), .in_2_des(in_des[1]), .in_2_data(in_data[1]),
    .in_3_vld(in_vld[2]), .in_3_des(in_des[2]), .in_3_data(in_data[2]),
    .in_4_vld(in_vld[3]), .in_4_des(in_des[3]), .in_4_data(in_data[3]),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_1_vld(o_vld[0]), .out_1_des(o_des[0]), .out_1_data(o_data[0]),
    .out_2_vld(o_vld[1]), .out_2_des(o_des[1]), .out_2_data(o_data[1]),
    .out_3_vld(o_vld[2]), .out_3_des(o_des[2]), .out_3_data(o_data[2]),
    .out_4_vld(o_vld[3]), .out_4_des(o_des[3]), .out_4_data(o_data[3]),
    .err_underflw(err_underflw)
  );

  // Reference model: a queue of raw swap codes and the last delivered bundle.
  logic [3:0] m_q[$];
  logic       m_vld = 1'b0;
  logic       m_err = 1'b0;
  logic [3:0] m_kvld = '0;
  logic [3:0] m_des[4] = '{default: '0};
  logic [15:0] m_data[4] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_vld = 1'b0;
      m_err = 1'b0;
      m_kvld = '0;
      for (int k = 0; k < 4; k++) begin m_des[k] = '0; m_data[k] = '0; end
    end else if (flush) begin
      m_q.delete();
      m_vld = 1'b0;
      m_err = 1'b0;
    end else begin
      bit do_pop, do_push;
      int src[4];
      logic [3:0] code;
      int a;
      do_pop  = wb_vld && (m_q.size() != 0) && (!m_vld || out_rdy);
      do_push = issue_vld && (m_q.size() < 4);
      if (wb_vld && m_q.size() == 0) m_err = 1'b1;
      if (do_pop) begin
        code = m_q.pop_front();
        for (int k = 0; k < 4; k++) src[k] = k;
        // A code with exactly two instruction bits set names the two swapped slots.
        if ($countones(code) == 2) begin
          a = -1;
          for (int k = 0; k < 4; k++) begin
            if (code[3-k]) begin
              if (a < 0) a = k;
              else begin src[a] = k; src[k] = a; end
            end
          end
        end
        for (int k = 0; k < 4; k++) begin
          m_kvld[k] = in_vld[src[k]];
          m_des[k]  = in_des[src[k]];
          m_data[k] = in_data[src[k]];
        end
        m_vld = 1'b1;
      end else if (out_rdy) begin
        m_vld = 1'b0;
      end
      if (do_push) m_q.push_back(issue_swap);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("issue_rdy", 32'(issue_rdy), 32'(m_q.size() < 4));
    chk("wb_rdy", 32'(wb_rdy), 32'((m_q.size() != 0) && (!m_vld || out_rdy)));
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    chk("err_underflw", 32'(err_underflw), 32'(m_err));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_%0d_vld", k + 1), 32'(o_vld[k]), 32'(m_vld && m_kvld[k]));
      chk($sformatf("out_%0d_des", k + 1), 32'(o_des[k]), 32'(m_des[k]));
      chk($sformatf("out_%0d_data", k + 1), 32'(o_data[k]), 32'(m_data[k]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic [15:0] d1, d2, d3, d4);
    in_data[0] = d1; in_data[1] = d2; in_data[2] = d3; in_data[3] = d4;
    for (int k = 0; k < 4; k++) in_des[k] = in_data[k][3:0] ^ 4'(k);
  endtask

  task automatic chk_out(input string name, input logic [15:0] e1, e2, e3, e4);
    chk({name, "_1"}, 32'(o_data[0]), 32'(e1));
    chk({name, "_2"}, 32'(o_data[1]), 32'(e2));
    chk({name, "_3"}, 32'(o_data[2]), 32'(e3));
    chk({name, "_4"}, 32'(o_data[3]), 32'(e4));
  endtask

  initial begin
    // Reset state.
    cyc(); cyc();
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
    chk("rst_wb_rdy", 32'(wb_rdy), 32'd0);
    chk("rst_err", 32'(err_underflw), 32'd0);
    rst_n = 1'b1;
    in_vld = 4'b1111;
    out_rdy = 1'b1;

    // Swap 1<->4.
    issue_vld = 1'b1; issue_swap = 4'b1001;
    cyc();
    issue_vld = 1'b0;
    lanes(16'hA1, 16'hB2, 16'hC3, 16'hD4); wb_vld = 1'b1;
    cyc();
    wb_vld = 1'b0;
    chk("t1_out_vld", 32'(out_vld), 32'd1);
    chk_out("t1", 16'hD4, 16'hB2, 16'hC3, 16'hA1);
    cyc();
    chk("t1_drain", 32'(out_vld), 32'd0);

    // Identity, 2<->3, 3<->4 back-to-back.
    issue_vld = 1'b1;
    issue_swap = 4'b0000; cyc();
    issue_swap = 4'b0110; cyc();
    issue_swap = 4'b0011; cyc();
    issue_vld = 1'b0;
    lanes(16'd1, 16'd2, 16'd3, 16'd4); wb_vld = 1'b1;
    cyc(); chk_out("t2a", 16'd1, 16'd2, 16'd3, 16'd4);
    cyc(); chk_out("t2b", 16'd1, 16'd3, 16'd2, 16'd4);
    cyc(); chk_out("t2c", 16'd1, 16'd2, 16'd4, 16'd3);
    wb_vld = 1'b0;
    cyc();

    // Fill to DEPTH; a 5th issue must be ignored.
    issue_vld = 1'b1;
    issue_swap = 4'b1100; cyc();
    issue_swap = 4'b1010; cyc();
    issue_swap = 4'b0101; cyc();
    issue_swap = 4'b0000; cyc();
    chk("t3_full", 32'(issue_rdy), 32'd0);
    issue_swap = 4'b1001; cyc();
    issue_vld = 1'b0;
    lanes(16'd5, 16'd6, 16'd7, 16'd8); wb_vld = 1'b1;
    cyc();
    wb_vld = 1'b0;
    chk("t3_rdy_after_pop", 32'(issue_rdy), 32'd1);
    chk_out("t3a", 16'd6, 16'd5, 16'd7, 16'd8);
    wb_vld = 1'b1; in_vld = 4'b1011;
    cyc(); chk_out("t3b", 16'd7, 16'd6, 16'd5, 16'd8);
    cyc(); chk_out("t3c", 16'd5, 16'd8, 16'd7, 16'd6);
    cyc(); chk_out("t3d", 16'd5, 16'd6, 16'd7, 16'd8);
    wb_vld = 1'b0; in_vld = 4'b1111;
    chk("t3_empty", 32'(wb_rdy), 32'd0);
    cyc();

    // Backpressure hold with two queued bundles.
    issue_vld = 1'b1;
    issue_swap = 4'b0011; cyc();
    issue_swap = 4'b1001; cyc();
    issue_vld = 1'b0;
    out_rdy = 1'b0; wb_vld = 1'b1; lanes(16'h11, 16'h22, 16'h33, 16'h44);
    cyc();
    lanes(16'h55, 16'h66, 16'h77, 16'h88);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_hold_wb_rdy", 32'(wb_rdy), 32'd0);
      chk_out("t4_hold", 16'h11, 16'h22, 16'h44, 16'h33);
    end
    out_rdy = 1'b1;
    cyc(); chk_out("t4_second", 16'h88, 16'h66, 16'h77, 16'h55);
    wb_vld = 1'b0;
    cyc(); cyc();

    // Underflow is sticky; flush clears it and wins over a same-cycle push.
    wb_vld = 1'b1; cyc(); wb_vld = 1'b0;
    cyc(); cyc();
    chk("t5_err_sticky", 32'(err_underflw), 32'd1);
    issue_vld = 1'b1;
    issue_swap = 4'b0101; cyc(); cyc(); cyc();
    flush = 1'b1; cyc();
    flush = 1'b0; issue_vld = 1'b0;
    chk("t5_flush_err", 32'(err_underflw), 32'd0);
    chk("t5_flush_vld", 32'(out_vld), 32'd0);
    chk("t5_flush_empty", 32'(wb_rdy), 32'd0);
    cyc();

    // Asynchronous reset mid-burst.
    issue_vld = 1'b1;
    issue_swap = 4'b1100; cyc(); cyc();
    issue_vld = 1'b0;
    wb_vld = 1'b1; lanes(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(out_vld), 32'd0);
    chk("t6_rst_data", 32'(o_data[0]), 32'd0);
    chk("t6_rst_rdy", 32'(issue_rdy), 32'd1);
    wb_vld = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
